// File: rtl/demux4x8_stream_pkg.sv
// Shared constants and types for the 1-to-4 byte stream demultiplexer.
//   WIDTH      : lane data width
//   N          : number of output lanes
//   SEL_W      : width of a lane index
//   lane_idx_t : lane index type (destination select, round-robin pointer)
package demux_pkg;
    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] lane_idx_t;
endpackage

// File: rtl/demux4x8_stream_if.sv
// Stream bus of the demultiplexer: one valid/ready input stream plus four
// registered output lanes with per-lane valid/ready.
//   master : upstream producer and downstream consumers (drives I, I_valid,
//            S, RR, O_ready; observes I_ready, O0..O3, O_valid)
//   slave  : the demultiplexer itself
interface demux4x8_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH = demux_pkg::WIDTH
);
    logic [WIDTH-1:0] I;
    logic             I_valid;
    logic             I_ready;
    lane_idx_t        S;
    logic             RR;
    logic [WIDTH-1:0] O0;
    logic [WIDTH-1:0] O1;
    logic [WIDTH-1:0] O2;
    logic [WIDTH-1:0] O3;
    logic [3:0]       O_valid;
    logic [3:0]       O_ready;

    modport master (
        output I, I_valid, S, RR, O_ready,
        input  I_ready, O0, O1, O2, O3, O_valid
    );

    modport slave (
        input  I, I_valid, S, RR, O_ready,
        output I_ready, O0, O1, O2, O3, O_valid
    );
endinterface

// File: rtl/demux4x8_stream_lane_reg.sv
// One-entry holding register for a single output lane.
//   CLK, RESET : clock, synchronous active-high reset
//   load       : write D this cycle (takes priority over a drain)
//   D          : incoming beat
//   take       : consumer accepts the held beat this cycle
//   Q          : held data (stale once valid drops)
//   valid      : lane holds a beat
//   free       : lane can accept a beat this cycle (empty or draining)
module lane_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             take,
    output logic [WIDTH-1:0] Q,
    output logic             valid,
    output logic             free
);
    // A draining lane counts as free so a beat can pass straight through.
    assign free = !valid || take;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            Q     <= D;
            valid <= 1'b1;
        end else if (take) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux4x8_stream.sv
// Registered 1-to-4 demultiplexer for byte streams. Each accepted beat is
// routed to one lane register, chosen by S or by an internal round-robin
// pointer (RR = 1).
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : stream interface (slave side)
//   rr_ptr     : current round-robin pointer, for observation
module demux4x8_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = demux_pkg::WIDTH,
    parameter int N     = demux_pkg::N
) (
    input  logic              CLK,
    input  logic              RESET,
    demux4x8_stream_if.slave  bus,
    output lane_idx_t         rr_ptr
);
    lane_idx_t                 dst;
    logic                      in_ready;
    logic                      accept;
    logic [N-1:0]              load;
    logic [N-1:0]              free;
    logic [N-1:0]              valid;
    logic [N-1:0][WIDTH-1:0]   q;

    assign dst      = bus.RR ? rr_ptr : bus.S;
    // Only the addressed lane gates the input; a stalled lane blocks the
    // stream rather than redirecting the beat elsewhere.
    assign in_ready = !RESET && free[dst];
    assign accept   = bus.I_valid && in_ready;

    always_comb begin
        load = '0;
        if (accept) load[dst] = 1'b1;
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        lane_reg #(.WIDTH(WIDTH)) u_lane (
            .CLK   (CLK),
            .RESET (RESET),
            .load  (load[k]),
            .D     (bus.I),
            .take  (bus.O_ready[k]),
            .Q     (q[k]),
            .valid (valid[k]),
            .free  (free[k])
        );
    end

    // Pointer only moves on a round-robin accept; explicit-mode traffic
    // leaves it where it was.
    always_ff @(posedge CLK) begin
        if (RESET)
            rr_ptr <= '0;
        else if (accept && bus.RR)
            rr_ptr <= rr_ptr + 1'b1;
    end

    assign bus.I_ready = in_ready;
    assign bus.O_valid = valid;
    assign bus.O0      = q[0];
    assign bus.O1      = q[1];
    assign bus.O2      = q[2];
    assign bus.O3      = q[3];
endmodule
